sraml_mem_responder: RTL and testbench
======================================

SRAML_MEM_RESPONDER -- requirements
Module: sraml_mem_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, meaning word-index bits of the internal memory (2^ADDR_W 32-bit words).
REQ-002 SHALL have parameter LATENCY, default 2, meaning cycles from request acceptance to data_ok; legal range 1..7.
REQ-003 SHALL have parameter DEPTH, default 4, meaning maximum outstanding transactions; power of two, 2..8.
REQ-004 SHALL use one clock and asynchronous active-high reset, as listed below.
REQ-005 clk  input  1  clock; all state updates on the rising edge.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 req  input  1  initiator request valid.
REQ-008 wr  input  1  1 = write, 0 = read.
REQ-009 size  input  2  0 byte, 1 halfword, 2 word, 3 reserved.
REQ-010 addr  input  32  byte address; bits [ADDR_W+1:2] index memory, upper bits ignored.
REQ-011 wdata  input  32  write data, already lane-aligned.
REQ-012 addr_ok  output  1  request accepted this cycle when high with req.
REQ-013 data_ok  output  1  one-cycle completion pulse per accepted transaction.
REQ-014 rdata  output  32  read word, valid only while data_ok is high for a read.
REQ-015 err  output  1  misalignment flag, qualified by data_ok (see Configuration).

Function
REQ-016 SHALL accept a transaction on each rising edge where req and addr_ok are both high.
REQ-017 SHALL drive addr_ok = !full, where full means DEPTH entries outstanding; no same-cycle bypass from a retiring entry.
REQ-018 SHALL perform writes in the acceptance cycle; byte strobes: size 0 -> lane addr[1:0]; size 1 -> lanes {addr[1],0} and {addr[1],1}; size 2 or 3 -> all four lanes.
REQ-019 SHALL sample the read word at acceptance and store it with the entry, so a later write never alters an earlier read.
REQ-020 SHALL raise data_ok exactly LATENCY cycles after acceptance; an entry accepted at edge T retires in the cycle following edge T+LATENCY-1.
REQ-021 SHALL complete transactions strictly in acceptance order, one data_ok per transaction.
REQ-022 SHALL drive rdata to 0 when data_ok is low and on write completions.
REQ-023 SHALL leave the occupancy count unchanged on simultaneous accept and retire.
REQ-024 SHALL ignore wr, size, addr and wdata when req is low or addr_ok is low.
REQ-025 SHALL wrap FIFO read and write pointers modulo DEPTH.

Reset
REQ-026 SHALL, while rst is high, hold addr_ok=0, data_ok=0, rdata=0, err=0, pointers and count at 0.
REQ-027 SHALL discard all outstanding transactions on reset mid-operation; no data_ok for them after reset release.
REQ-028 SHALL NOT reset memory contents; writes completed before reset persist.

Configuration
REQ-029 SHALL support macro SRAML_RESP_ALIGN_CHECK_EN.
REQ-030 With the macro defined: err=1 with data_ok for size 1 with addr[0]=1, size 2 with addr[1:0]!=0, or size 3; misaligned writes are suppressed (no memory change), and misaligned reads return rdata=0.
REQ-031 Without the macro: err tied to 0; misaligned writes use the REQ-018 strobes; reads return the addressed word.

Structure
REQ-032 SHALL place size encodings (SZ_BYTE, SZ_HALF, SZ_WORD) and the strobe-generation function in shared package sraml_pkg.
REQ-033 SHALL implement outstanding-entry storage as a sub-module sraml_resp_fifo: entry = {wr, err, rdata, age counter}.

Verification
REQ-034 Word write 0xDEADBEEF to 0x10, then word read 0x10, LATENCY=2 -> two data_ok pulses at acceptance+2; read rdata=0xDEADBEEF.
REQ-035 Byte write 0xAA at 0x13 over 0x11223344, then word read -> rdata=0xAA223344.
REQ-036 Hold req high with DEPTH=4, LATENCY=7 -> addr_ok low after 4 acceptances; first retire re-enables addr_ok the following cycle.
REQ-037 Read 0x20 (holding 0x5), then write 0x9 to 0x20 on the next cycle -> read completes with rdata=0x5.
REQ-038 Assert rst with 3 outstanding transactions -> no data_ok after release; memory retains prior writes.
REQ-039 With SRAML_RESP_ALIGN_CHECK_EN defined, word write to 0x22 -> data_ok with err=1; memory unchanged.

Source files
------------

// File: rtl/sraml_pkg.sv
// sraml_pkg: shared size encodings, FIFO entry layout and lane helpers for the SRAM-like responder
package sraml_pkg;
    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;
    localparam int AGE_W = 3;

    typedef struct packed {
        logic             wr;
        logic             err;
        logic [31:0]      data;
        logic [AGE_W-1:0] age;
    } entry_t;

    function automatic logic [3:0] strobe(input logic [1:0] size, input logic [1:0] lane);
        return size == SZ_BYTE ? 4'b0001 << lane : size == SZ_HALF ? (lane[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    endfunction

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lane);
        return (size == SZ_HALF && lane[0]) || (size == SZ_WORD && lane != 2'd0) || size == 2'd3;
    endfunction
endpackage

// File: rtl/sraml_resp_fifo.sv
// sraml_resp_fifo: in-order outstanding-transaction queue; head retires once its age reaches LATENCY
module sraml_resp_fifo
    import sraml_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic        push_wr,
    input  logic        push_err,
    input  logic [31:0] push_data,
    output logic        full,
    output logic        ready,
    output logic        head_wr,
    output logic        head_err,
    output logic [31:0] head_data
);
    localparam int PW = $clog2(DEPTH);

    entry_t        ent [DEPTH];
    logic [PW-1:0] rp, wp;
    logic [PW:0]   cnt;

    assign full      = cnt == (PW+1)'(DEPTH);
    assign ready     = cnt != '0 && ent[rp].age == AGE_W'(LATENCY);
    assign head_wr   = ent[rp].wr;
    assign head_err  = ent[rp].err;
    assign head_data = ent[rp].data;

    // Ages saturate at LATENCY; only the head is ever compared, and order is preserved by construction
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rp  <= '0;
            wp  <= '0;
            cnt <= '0;
            for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++)
                if (ent[i].age != AGE_W'(LATENCY)) ent[i].age <= ent[i].age + 1'b1;
            if (push) begin
                ent[wp] <= '{wr: push_wr, err: push_err, data: push_data, age: AGE_W'(1)};
                wp      <= wp + 1'b1;
            end
            if (ready) rp <= rp + 1'b1;
            cnt <= cnt + (PW+1)'(push) - (PW+1)'(ready);
        end
    end
endmodule

// File: rtl/sraml_mem_responder.sv
// sraml_mem_responder: SRAM-like slave with fixed-latency in-order completion over an internal word memory.
// Define SRAML_RESP_ALIGN_CHECK_EN to flag and suppress misaligned accesses.
module sraml_mem_responder
    import sraml_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2,
    parameter int DEPTH   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata,
    output logic        err
);
    logic [31:0]       mem [2**ADDR_W];
    logic [ADDR_W-1:0] idx;
    logic [3:0]        strb;
    logic [31:0]       head_data;
    logic              accept, mis, full, ready, head_wr, head_err, unused_addr;

    assign idx         = addr[ADDR_W+1:2];
    assign unused_addr = ^addr[31:ADDR_W+2];
    assign strb        = strobe(size, addr[1:0]);
    assign accept      = req && addr_ok;
`ifdef SRAML_RESP_ALIGN_CHECK_EN
    assign mis = misaligned(size, addr[1:0]);
`else
    assign mis = 1'b0;
`endif
    assign addr_ok = !rst && !full;
    assign data_ok = ready;
    assign rdata   = ready && !head_wr ? head_data : '0;
    assign err     = ready && head_err;

    // Memory deliberately has no reset so contents survive a responder reset
    always_ff @(posedge clk) begin
        if (accept && wr && !mis)
            for (int i = 0; i < 4; i++)
                if (strb[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
    end

    sraml_resp_fifo #(.DEPTH(DEPTH), .LATENCY(LATENCY)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (accept),
        .push_wr   (wr),
        .push_err  (mis),
        .push_data (wr || mis ? 32'd0 : mem[idx]),
        .full      (full),
        .ready     (ready),
        .head_wr   (head_wr),
        .head_err  (head_err),
        .head_data (head_data)
    );
endmodule

// File: tb/tb_sraml_mem_responder.sv
// tb_sraml_mem_responder: randomized and directed checks against a byte-array / due-cycle queue model
module tb_sraml_mem_responder;
    localparam int AW    = 10;
    localparam int LAT   = 5;
    localparam int DEPTH = 4;
    localparam int NW    = 64;

    logic        clk = 0, rst = 1, req = 0, wr = 0;
    logic [1:0]  size = 0;
    logic [31:0] addr = 0, wdata = 0;
    logic        addr_ok, data_ok, err;
    logic [31:0] rdata;

    always #5 clk = ~clk;

    sraml_mem_responder #(.ADDR_W(AW), .LATENCY(LAT), .DEPTH(DEPTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .wr      (wr),
        .size    (size),
        .addr    (addr),
        .wdata   (wdata),
        .addr_ok (addr_ok),
        .data_ok (data_ok),
        .rdata   (rdata),
        .err     (err)
    );

    typedef struct {
        int          due;
        logic        wr;
        logic        err;
        logic [31:0] data;
    } txn_t;

    txn_t        q[$];
    logic [7:0]  mb [NW*4];
    int          cyc = 0, checks = 0, errors = 0;
    logic [31:0] last_rd = 0;
    logic        last_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic bad(input logic [1:0] s, input logic [1:0] a);
`ifdef SRAML_RESP_ALIGN_CHECK_EN
        return s == 2'd3 || (s == 2'd1 && a[0]) || (s == 2'd2 && a != 2'd0);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] rnd_addr();
        logic [31:0] a;
        a = $urandom;
        a[AW+1:2] = AW'($urandom_range(0, NW-1));
        return a;
    endfunction

    task automatic cycle(output logic acc);
        txn_t t;
        logic ok, dv;
        int   base;
        @(negedge clk);
        ok = q.size() < DEPTH;
        dv = 1'b0;
        if (q.size() > 0) dv = q[0].due == cyc;
        check("addr_ok", 32'(addr_ok), 32'(ok));
        check("data_ok", 32'(data_ok), 32'(dv));
        if (dv) begin
            check("rdata", rdata, q[0].wr ? 32'd0 : q[0].data);
            check("err", 32'(err), 32'(q[0].err));
            if (!q[0].wr) last_rd = rdata;
            last_err = err;
            void'(q.pop_front());
        end else begin
            check("rdata_idle", rdata, 32'd0);
            check("err_idle", 32'(err), 32'd0);
        end
        acc = req && ok;
        if (acc) begin
            base   = int'(addr[AW+1:2]) * 4;
            t.due  = cyc + LAT;
            t.wr   = wr;
            t.err  = bad(size, addr[1:0]);
            t.data = (wr || t.err) ? 32'd0 : {mb[base+3], mb[base+2], mb[base+1], mb[base]};
            if (wr && !t.err)
                for (int b = 0; b < 4; b++)
                    if (size == 2'd0 ? b == int'(addr[1:0]) : size == 2'd1 ? b / 2 == int'(addr[1]) : 1'b1)
                        mb[base+b] = wdata[8*b +: 8];
            q.push_back(t);
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic drive(input logic r, input logic w, input logic [1:0] s, input logic [31:0] a,
                         input logic [31:0] d, output logic acc);
        req = r; wr = w; size = s; addr = a; wdata = d;
        cycle(acc);
    endtask

    task automatic send(input logic w, input logic [1:0] s, input logic [31:0] a, input logic [31:0] d);
        logic acc;
        acc = 1'b0;
        for (int k = 0; k < 20 && !acc; k++) drive(1'b1, w, s, a, d, acc);
        if (!acc) check("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int k = 0; k < n; k++) drive(1'b0, 1'($urandom), 2'($urandom), $urandom, $urandom, acc);
    endtask

    task automatic rst_cycle();
        @(negedge clk);
        check("rst_addr_ok", 32'(addr_ok), 32'd0);
        check("rst_data_ok", 32'(data_ok), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_err", 32'(err), 32'd0);
        @(posedge clk);
        cyc++;
        #1;
    endtask

    initial begin
        logic acc;
        int   n, stall_at;
        repeat (2) rst_cycle();
        rst = 0;
        for (int w = 0; w < NW; w++) send(1'b1, 2'd2, {$urandom} & ~32'hFFF | 32'(w * 4), $urandom);
        idle(LAT + 2);

        send(1'b1, 2'd2, 32'h10, 32'hDEADBEEF);
        send(1'b0, 2'd2, 32'h10, 32'h0);
        idle(LAT + 2);
        check("word_rw", last_rd, 32'hDEADBEEF);

        send(1'b1, 2'd2, 32'h10, 32'h11223344);
        send(1'b1, 2'd0, 32'h13, 32'hAA000000);
        send(1'b0, 2'd2, 32'h10, 32'h0);
        idle(LAT + 2);
        check("byte_merge", last_rd, 32'hAA223344);

        send(1'b1, 2'd2, 32'h20, 32'h5);
        idle(LAT + 2);
        send(1'b0, 2'd2, 32'h20, 32'h0);
        send(1'b1, 2'd2, 32'h20, 32'h9);
        idle(LAT + 2);
        check("read_snapshot", last_rd, 32'h5);

        n = 0;
        stall_at = -1;
        for (int k = 0; k < 14; k++) begin
            drive(1'b1, 1'b0, 2'd2, rnd_addr(), 32'h0, acc);
            if (acc) n++;
            else if (stall_at < 0) stall_at = n;
        end
        check("fill_count", 32'(stall_at), 32'(DEPTH));
        idle(LAT + 2);

        send(1'b1, 2'd2, 32'h30, 32'h77);
        send(1'b0, 2'd2, 32'h10, 32'h0);
        send(1'b0, 2'd2, 32'h20, 32'h0);
        req = 0;
        rst = 1;
        q.delete();
        repeat (2) rst_cycle();
        rst = 0;
        idle(LAT + 3);
        send(1'b0, 2'd2, 32'h30, 32'h0);
        idle(LAT + 2);
        check("mem_persist", last_rd, 32'h77);

`ifdef SRAML_RESP_ALIGN_CHECK_EN
        send(1'b1, 2'd2, 32'h22, 32'h12345678);
        idle(LAT + 2);
        check("misalign_err", 32'(last_err), 32'd1);
        send(1'b0, 2'd2, 32'h20, 32'h0);
        idle(LAT + 2);
        check("misalign_nowrite", last_rd, 32'h9);
`endif

        for (int k = 0; k < 600; k++)
            drive(1'($urandom_range(0, 9) < 7), 1'($urandom), 2'($urandom), rnd_addr(), $urandom, acc);
        idle(LAT + 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
